// File: rtl/lattice_display_reader.sv
// lattice_display_reader: scans the 9 lattice distribution banks in step with video timing
// and maps each lattice cell to an RGB pixel (density, ux, uy or raw centre-channel view).
// Latency: fixed 6 cycles from hcount/vcount to RGB; syncs/active delayed by the same 6 cycles.
// Backpressure: none; one pixel per clock. Reads are issued only for in-grid, active pixels
// while the solver is idle.
//
// Ports:
//   clk_in, rst_in            clock, synchronous active-high reset
//   hcount_in, vcount_in      pixel coordinates from the timing generator
//   hsync_in, vsync_in,
//   active_in                 timing strobes, re-emitted as *_out aligned with the pixel
//   lbm_state_in              solver state; only 3 (WAITING) allows reads
//   mode_in                   00 density, 01 ux, 10 uy, 11 raw centre channel
//   bram_data_in              9 bank read bytes, valid 2 cycles after addr_out
//   addr_out, read_en_out     shared read address (replicated on all 9 banks) and request
//   red_out/green_out/blue_out, hsync_out/vsync_out/active_out   registered pixel output
module lattice_display_reader #(
  parameter int  BRAM_DEPTH  = 31570,
  parameter int  GRID_W      = 205,
  parameter int  GRID_H      = 154,
  parameter int  SCALE_SHIFT = 2,
  localparam int BRAM_SIZE   = $clog2(BRAM_DEPTH)
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic [10:0]               hcount_in,
  input  logic [9:0]                vcount_in,
  input  logic                      hsync_in,
  input  logic                      vsync_in,
  input  logic                      active_in,
  input  logic [1:0]                lbm_state_in,
  input  logic [1:0]                mode_in,
  input  logic [8:0][7:0]           bram_data_in,
  output logic [8:0][BRAM_SIZE-1:0] addr_out,
  output logic                      read_en_out,
  output logic [7:0]                red_out,
  output logic [7:0]                green_out,
  output logic [7:0]                blue_out,
  output logic                      hsync_out,
  output logic                      vsync_out,
  output logic                      active_out
);

  localparam int CXW = 11 - SCALE_SHIFT;
  localparam int CYW = 10 - SCALE_SHIFT;
  localparam logic [1:0] ST_WAITING = 2'd3;

  // Bank indices
  localparam int B_C  = 0;
  localparam int B_N  = 1;
  localparam int B_NE = 2;
  localparam int B_E  = 3;
  localparam int B_SE = 4;
  localparam int B_S  = 5;
  localparam int B_SW = 6;
  localparam int B_W  = 7;
  localparam int B_NW = 8;

  // Per-pixel decisions taken at S0 and carried down the pipeline with the pixel.
  typedef struct packed {
    logic       active;
    logic       in_grid;
    logic       idle;
    logic [1:0] mode;
  } flags_t;

  flags_t         flg [0:4];   // flg[k] belongs to the pixel currently in stage Sk
  logic [CXW-1:0] s0_cx;
  logic [CYW-1:0] s0_cy;
  logic [4:0]     hs_dly;
  logic [4:0]     vs_dly;
  logic [11:0]    s4_rho;
  logic [10:0]    s4_ux;       // two's complement
  logic [10:0]    s4_uy;       // two's complement
  logic [7:0]     s4_c;

  // ---------------- S0 decode ----------------
  logic [CXW-1:0] cx;
  logic [CYW-1:0] cy;
  logic           in_grid;

  assign cx      = hcount_in[10:SCALE_SHIFT];
  assign cy      = vcount_in[9:SCALE_SHIFT];
  assign in_grid = (32'(cx) < 32'(GRID_W)) && (32'(cy) < 32'(GRID_H));

  // Sub-cell pixel bits select nothing: every pixel of a cell shows the same colour.
  logic unused_subcell;
  assign unused_subcell = ^{hcount_in[SCALE_SHIFT-1:0], vcount_in[SCALE_SHIFT-1:0]};

  // ---------------- S1 address ----------------
  logic                 rd_req;
  logic [BRAM_SIZE-1:0] addr_calc;

  assign rd_req    = flg[0].in_grid && flg[0].idle && flg[0].active;
  assign addr_calc = BRAM_SIZE'(s0_cy) * BRAM_SIZE'(GRID_W) + BRAM_SIZE'(s0_cx);

  // ---------------- S4 moments ----------------
  logic [11:0] rho_sum;
  logic [11:0] ux_pos, ux_neg, uy_pos, uy_neg;
  logic [11:0] ux_full, uy_full;

  always_comb begin
    rho_sum = '0;
    for (int b = 0; b < 9; b++) begin
      rho_sum = rho_sum + 12'(bram_data_in[b]);
    end
    ux_pos  = 12'(bram_data_in[B_E]) + 12'(bram_data_in[B_NE]) + 12'(bram_data_in[B_SE]);
    ux_neg  = 12'(bram_data_in[B_W]) + 12'(bram_data_in[B_SW]) + 12'(bram_data_in[B_NW]);
    uy_pos  = 12'(bram_data_in[B_N]) + 12'(bram_data_in[B_NE]) + 12'(bram_data_in[B_NW]);
    uy_neg  = 12'(bram_data_in[B_S]) + 12'(bram_data_in[B_SE]) + 12'(bram_data_in[B_SW]);
    // Range is +/-765, so the low 11 bits hold the exact signed value.
    ux_full = ux_pos - ux_neg;
    uy_full = uy_pos - uy_neg;
  end

  // ---------------- S5 colour map ----------------
  function automatic logic [7:0] sat255(input logic [12:0] v);
    return (v > 13'd255) ? 8'hFF : v[7:0];
  endfunction

  // |v|*2; negation done in 12 bits so -(-765) does not wrap.
  function automatic logic [12:0] dbl_mag(input logic [10:0] v);
    logic [11:0] e;
    e = {v[10], v};
    if (v[10]) begin
      e = -e;
    end
    return {e, 1'b0};
  endfunction

  logic [23:0] pix;

  always_comb begin
    pix = '0;
    if (flg[4].active && flg[4].in_grid) begin
      if (!flg[4].idle) begin
        pix = 24'h404040;   // solver owns the BRAMs: show busy grey
      end else begin
        case (flg[4].mode)
          2'b00: pix = {3{s4_rho[11:4]}};
          2'b01: begin
            if (s4_ux[10])         pix[7:0]   = sat255(dbl_mag(s4_ux));
            else if (s4_ux != '0)  pix[23:16] = sat255(dbl_mag(s4_ux));
          end
          2'b10: begin
            if (s4_uy[10])         pix[7:0]   = sat255(dbl_mag(s4_uy));
            else if (s4_uy != '0)  pix[15:8]  = sat255(dbl_mag(s4_uy));
          end
          default: pix = {3{s4_c}};
        endcase
      end
    end
  end

  // ---------------- pipeline registers ----------------
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      s0_cx       <= '0;
      s0_cy       <= '0;
      for (int i = 0; i < 5; i++) begin
        flg[i] <= '0;
      end
      hs_dly      <= '0;
      vs_dly      <= '0;
      addr_out    <= '0;
      read_en_out <= 1'b0;
      s4_rho      <= '0;
      s4_ux       <= '0;
      s4_uy       <= '0;
      s4_c        <= '0;
      red_out     <= '0;
      green_out   <= '0;
      blue_out    <= '0;
      hsync_out   <= 1'b0;
      vsync_out   <= 1'b0;
      active_out  <= 1'b0;
    end else begin
      // S0
      s0_cx          <= cx;
      s0_cy          <= cy;
      flg[0].active  <= active_in;
      flg[0].in_grid <= in_grid;
      flg[0].idle    <= (lbm_state_in == ST_WAITING);
      flg[0].mode    <= mode_in;
      // S1: address only moves on a real read, so it never leaves the lattice range.
      read_en_out <= rd_req;
      if (rd_req) begin
        addr_out <= {9{addr_calc}};
      end
      // S1..S4 flag carry
      for (int i = 1; i < 5; i++) begin
        flg[i] <= flg[i-1];
      end
      // S4
      s4_rho <= rho_sum;
      s4_ux  <= ux_full[10:0];
      s4_uy  <= uy_full[10:0];
      s4_c   <= bram_data_in[B_C];
      // S5
      {red_out, green_out, blue_out} <= pix;
      // Timing strobes: 5-stage chain plus the output register = 6 cycles.
      hs_dly     <= {hs_dly[3:0], hsync_in};
      vs_dly     <= {vs_dly[3:0], vsync_in};
      hsync_out  <= hs_dly[4];
      vsync_out  <= vs_dly[4];
      active_out <= flg[4].active;
    end
  end

endmodule

// File: tb/tb_lattice_display_reader.sv
module tb_lattice_display_reader;

  localparam int AW = 15;

  logic               clk_in = 1'b0;
  logic               rst_in = 1'b1;
  logic [10:0]        hcount_in = '0;
  logic [9:0]         vcount_in = '0;
  logic               hsync_in = 1'b0;
  logic               vsync_in = 1'b0;
  logic               active_in = 1'b0;
  logic [1:0]         lbm_state_in = 2'd3;
  logic [1:0]         mode_in = 2'd0;
  logic [8:0][7:0]    bram_data_in = '0;
  logic [8:0][AW-1:0] addr_out;
  logic               read_en_out;
  logic [7:0]         red_out, green_out, blue_out;
  logic               hsync_out, vsync_out, active_out;

  always #5 clk_in = ~clk_in;

  lattice_display_reader dut (
    .clk_in(clk_in), .rst_in(rst_in), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .active_in(active_in),
    .lbm_state_in(lbm_state_in), .mode_in(mode_in), .bram_data_in(bram_data_in),
    .addr_out(addr_out), .read_en_out(read_en_out), .red_out(red_out),
    .green_out(green_out), .blue_out(blue_out), .hsync_out(hsync_out),
    .vsync_out(vsync_out), .active_out(active_out)
  );

  typedef struct {
    int   h;
    int   v;
    logic hs;
    logic vs;
    logic act;
    int   st;
    int   mode;
  } stim_t;

  typedef struct {
    logic [23:0] rgb;
    logic        hs;
    logic        vs;
    logic        act;
  } exp_t;

  typedef struct {
    logic ren;
    int   addr;
  } addr_exp_t;

  int        checks = 0;
  int        passes = 0;
  exp_t      sb_pix[$];
  addr_exp_t sb_addr[$];
  int        last_addr = 0;

  // Bank contents: either a constant per bank or varying with address.
  logic [7:0] bank_val [9];
  bit         mix_en = 1'b0;

  function automatic logic [7:0] bank_data(int b, int addr);
    if (mix_en) return 8'(int'(bank_val[b]) + ((addr + b) & 15));
    return bank_val[b];
  endfunction

  // BRAM with 2-cycle read latency
  logic [8:0][7:0] bram_d1 = '0;
  always @(posedge clk_in) begin
    for (int b = 0; b < 9; b++) bram_d1[b] <= bank_data(b, int'(addr_out[b]));
    bram_data_in <= bram_d1;
  end

  function automatic logic [7:0] sat(int v);
    return (v > 255) ? 8'hFF : 8'(v);
  endfunction

  function automatic exp_t model(stim_t s);
    exp_t e;
    int cx, cy, a, rho, ux, uy;
    int d[9];
    e.hs = s.hs; e.vs = s.vs; e.act = s.act; e.rgb = 24'h0;
    cx = s.h / 4;
    cy = s.v / 4;
    if (!s.act || cx >= 205 || cy >= 154) return e;
    if (s.st != 3) begin
      e.rgb = 24'h404040;
      return e;
    end
    a = cy * 205 + cx;
    rho = 0;
    for (int b = 0; b < 9; b++) begin
      d[b] = int'(bank_data(b, a));
      rho += d[b];
    end
    ux = (d[3] + d[2] + d[4]) - (d[7] + d[6] + d[8]);
    uy = (d[1] + d[2] + d[8]) - (d[5] + d[4] + d[6]);
    case (s.mode)
      0: e.rgb = {3{8'(rho / 16)}};
      1: if (ux > 0) e.rgb = {sat(2 * ux), 16'h0};
         else if (ux < 0) e.rgb = {16'h0, sat(-2 * ux)};
      2: if (uy > 0) e.rgb = {8'h0, sat(2 * uy), 8'h0};
         else if (uy < 0) e.rgb = {16'h0, sat(-2 * uy)};
      default: e.rgb = {3{8'(d[0])}};
    endcase
    return e;
  endfunction

  task automatic drive(input stim_t s);
    hcount_in    = 11'(s.h);
    vcount_in    = 10'(s.v);
    hsync_in     = s.hs;
    vsync_in     = s.vs;
    active_in    = s.act;
    lbm_state_in = 2'(s.st);
    mode_in      = 2'(s.mode);
  endtask

  task automatic push_exp(input stim_t s);
    addr_exp_t ae;
    ae.ren = s.act && (s.h / 4 < 205) && (s.v / 4 < 154) && (s.st == 3);
    if (ae.ren) last_addr = (s.v / 4) * 205 + s.h / 4;
    ae.addr = last_addr;
    sb_addr.push_back(ae);
    sb_pix.push_back(model(s));
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_banks(input logic [7:0] c, n, ne, e, se, s, sw, w, nw);
    bank_val[0] = c;  bank_val[1] = n;  bank_val[2] = ne;
    bank_val[3] = e;  bank_val[4] = se; bank_val[5] = s;
    bank_val[6] = sw; bank_val[7] = w;  bank_val[8] = nw;
  endtask

  function automatic stim_t mk(int h, int v, logic hs, logic vs, logic act, int st, int mode);
    stim_t s;
    s.h = h; s.v = v; s.hs = hs; s.vs = vs; s.act = act; s.st = st; s.mode = mode;
    return s;
  endfunction

  // ---------------------------------------------------------------
  task automatic test_reset();
    rst_in = 1'b1;
    drive(mk(0, 0, 1'b1, 1'b1, 1'b1, 3, 0));
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({red_out, green_out, blue_out, hsync_out, vsync_out, active_out} !== 27'h0) begin
        $display("FAIL reset_out[%0d]: got rgb=%02h%02h%02h hs=%b vs=%b act=%b, want all 0",
                 i, red_out, green_out, blue_out, hsync_out, vsync_out, active_out);
      end else passes++;
      checks++;
      if (read_en_out !== 1'b0 || addr_out !== '0) begin
        $display("FAIL reset_addr[%0d]: got ren=%b addr=%0d, want ren=0 addr=0",
                 i, read_en_out, addr_out[0]);
      end else passes++;
    end
    rst_in = 1'b0;
    last_addr = 0;
    sb_pix.delete();
    sb_addr.delete();
  endtask

  task automatic test_density();
    stim_t stim[$];
    exp_t ex;
    addr_exp_t ae;
    mix_en = 1'b0;
    set_banks(8'h0A, 8'h0A, 8'h0A, 8'h0A, 8'h0A, 8'h0A, 8'h0A, 8'h0A, 8'h0A);
    stim.push_back(mk(0, 0, 1'b0, 1'b0, 1'b1, 3, 0));   // expect 050505, addr 0
    stim.push_back(mk(5, 2, 1'b0, 1'b0, 1'b1, 3, 3));   // raw centre 0A0A0A
    stim.push_back(mk(9, 9, 1'b0, 1'b0, 1'b1, 3, 1));   // balanced: ux=0
    for (int i = 0; i < stim.size() + 5; i++) begin
      if (i < stim.size()) begin drive(stim[i]); push_exp(stim[i]); end
      else drive(mk(0, 0, 1'b0, 1'b0, 1'b0, 3, 0));
      tick();
      if (i >= 1 && i <= stim.size()) begin
        ae = sb_addr.pop_front();
        checks++;
        if (read_en_out !== ae.ren || addr_out !== {9{AW'(ae.addr)}})
          $display("FAIL density_addr[%0d]: got ren=%b addr=%0d, want ren=%b addr=%0d",
                   i - 1, read_en_out, addr_out[0], ae.ren, ae.addr);
        else passes++;
      end
      if (i >= 5) begin
        ex = sb_pix.pop_front();
        checks++;
        if ({red_out, green_out, blue_out, hsync_out, vsync_out, active_out} !== {ex.rgb, ex.hs, ex.vs, ex.act})
          $display("FAIL density_pix[%0d]: got %02h%02h%02h/%b%b%b, want %06h/%b%b%b", i - 5,
                   red_out, green_out, blue_out, hsync_out, vsync_out, active_out, ex.rgb, ex.hs, ex.vs, ex.act);
        else passes++;
      end
    end
  endtask

  task automatic test_boundary();
    stim_t stim[$];
    exp_t ex;
    addr_exp_t ae;
    mix_en = 1'b1;
    set_banks(8'h30, 8'h21, 8'h12, 8'h43, 8'h54, 8'h05, 8'h16, 8'h27, 8'h38);
    stim.push_back(mk(819, 615, 1'b0, 1'b0, 1'b1, 3, 0));  // last cell, addr 31569
    stim.push_back(mk(820, 0,   1'b0, 1'b0, 1'b1, 3, 0));  // right of grid
    stim.push_back(mk(0,   616, 1'b0, 1'b0, 1'b1, 3, 0));  // below grid
    stim.push_back(mk(816, 612, 1'b0, 1'b0, 1'b1, 3, 3));  // same last cell, raw view
    stim.push_back(mk(819, 0,   1'b0, 1'b0, 1'b1, 3, 1));  // top-right cell
    stim.push_back(mk(0,   615, 1'b0, 1'b0, 1'b1, 3, 2));  // bottom-left cell
    stim.push_back(mk(400, 300, 1'b0, 1'b0, 1'b0, 3, 0));  // in grid but blanking
    stim.push_back(mk(1000, 700, 1'b0, 1'b0, 1'b1, 3, 0)); // far outside
    for (int i = 0; i < stim.size() + 5; i++) begin
      if (i < stim.size()) begin drive(stim[i]); push_exp(stim[i]); end
      else drive(mk(0, 0, 1'b0, 1'b0, 1'b0, 3, 0));
      tick();
      if (i >= 1 && i <= stim.size()) begin
        ae = sb_addr.pop_front();
        checks++;
        if (read_en_out !== ae.ren || addr_out !== {9{AW'(ae.addr)}})
          $display("FAIL boundary_addr[%0d]: got ren=%b addr=%0d, want ren=%b addr=%0d",
                   i - 1, read_en_out, addr_out[0], ae.ren, ae.addr);
        else passes++;
      end
      if (i >= 5) begin
        ex = sb_pix.pop_front();
        checks++;
        if ({red_out, green_out, blue_out, hsync_out, vsync_out, active_out} !== {ex.rgb, ex.hs, ex.vs, ex.act})
          $display("FAIL boundary_pix[%0d]: got %02h%02h%02h/%b%b%b, want %06h/%b%b%b", i - 5,
                   red_out, green_out, blue_out, hsync_out, vsync_out, active_out, ex.rgb, ex.hs, ex.vs, ex.act);
        else passes++;
      end
    end
  endtask

  task automatic test_velocity();
    stim_t s;
    exp_t ex;
    int mode;
    mix_en = 1'b0;
    for (int ph = 0; ph < 7; ph++) begin
      mode = 1;
      case (ph)
        0: set_banks(8'h00, 8'h00, 8'h7F, 8'h7F, 8'h7F, 8'h00, 8'h00, 8'h00, 8'h00); // FF0000
        1: set_banks(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h7F, 8'h7F, 8'h7F); // 0000FF
        2: set_banks(8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00); // 0A0000
        3: set_banks(8'h0A, 8'h0A, 8'h0A, 8'h0A, 8'h0A, 8'h0A, 8'h0A, 8'h0A, 8'h0A); // 000000
        4: set_banks(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF); // ux=-765
        5: begin set_banks(8'h00, 8'h10, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h10); mode = 2; end
        default: begin set_banks(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00); mode = 2; end
      endcase
      s = mk(40 + 4 * ph, 40, 1'b0, 1'b0, 1'b1, 3, mode);
      for (int i = 0; i < 6; i++) begin
        if (i == 0) begin drive(s); push_exp(s); end
        else drive(mk(0, 0, 1'b0, 1'b0, 1'b0, 3, 0));
        tick();
        if (i == 1) void'(sb_addr.pop_front());
        if (i == 5) begin
          ex = sb_pix.pop_front();
          checks++;
          if ({red_out, green_out, blue_out, active_out} !== {ex.rgb, ex.act})
            $display("FAIL velocity[%0d]: got %02h%02h%02h act=%b, want %06h act=%b", ph,
                     red_out, green_out, blue_out, active_out, ex.rgb, ex.act);
          else passes++;
        end
      end
    end
  endtask

  task automatic test_busy_sync();
    stim_t stim[$];
    exp_t ex;
    addr_exp_t ae;
    mix_en = 1'b1;
    set_banks(8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99);
    for (int k = 0; k < 12; k++)
      stim.push_back(mk(100 + 4 * k, 200, 1'(k == 3), 1'(k == 7), 1'(k != 9),
                        (k >= 4 && k <= 6) ? 2 : ((k == 8) ? 0 : 3), k % 4));
    for (int i = 0; i < stim.size() + 5; i++) begin
      if (i < stim.size()) begin drive(stim[i]); push_exp(stim[i]); end
      else drive(mk(0, 0, 1'b0, 1'b0, 1'b0, 3, 0));
      tick();
      if (i >= 1 && i <= stim.size()) begin
        ae = sb_addr.pop_front();
        checks++;
        if (read_en_out !== ae.ren || addr_out !== {9{AW'(ae.addr)}})
          $display("FAIL busy_addr[%0d]: got ren=%b addr=%0d, want ren=%b addr=%0d",
                   i - 1, read_en_out, addr_out[0], ae.ren, ae.addr);
        else passes++;
      end
      if (i >= 5) begin
        ex = sb_pix.pop_front();
        checks++;
        if ({red_out, green_out, blue_out, hsync_out, vsync_out, active_out} !== {ex.rgb, ex.hs, ex.vs, ex.act})
          $display("FAIL busy_pix[%0d]: got %02h%02h%02h/%b%b%b, want %06h/%b%b%b", i - 5,
                   red_out, green_out, blue_out, hsync_out, vsync_out, active_out, ex.rgb, ex.hs, ex.vs, ex.act);
        else passes++;
      end
    end
  endtask

  task automatic test_back_to_back();
    stim_t stim[$];
    exp_t ex;
    addr_exp_t ae;
    mix_en = 1'b1;
    for (int b = 0; b < 9; b++) bank_val[b] = 8'($urandom_range(0, 240));
    for (int k = 0; k < 40; k++)
      stim.push_back(mk($urandom_range(0, 900), $urandom_range(0, 650), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                        ($urandom_range(0, 1) == 1) ? 3 : $urandom_range(0, 2), $urandom_range(0, 3)));
    for (int i = 0; i < stim.size() + 5; i++) begin
      if (i < stim.size()) begin drive(stim[i]); push_exp(stim[i]); end
      else drive(mk(0, 0, 1'b0, 1'b0, 1'b0, 3, 0));
      tick();
      if (i >= 1 && i <= stim.size()) begin
        ae = sb_addr.pop_front();
        checks++;
        if (read_en_out !== ae.ren || addr_out !== {9{AW'(ae.addr)}})
          $display("FAIL b2b_addr[%0d]: got ren=%b addr=%0d, want ren=%b addr=%0d",
                   i - 1, read_en_out, addr_out[0], ae.ren, ae.addr);
        else passes++;
      end
      if (i >= 5) begin
        ex = sb_pix.pop_front();
        checks++;
        if ({red_out, green_out, blue_out, hsync_out, vsync_out, active_out} !== {ex.rgb, ex.hs, ex.vs, ex.act})
          $display("FAIL b2b_pix[%0d]: got %02h%02h%02h/%b%b%b, want %06h/%b%b%b", i - 5,
                   red_out, green_out, blue_out, hsync_out, vsync_out, active_out, ex.rgb, ex.hs, ex.vs, ex.act);
        else passes++;
      end
    end
  endtask

  // Reset held for 3 cycles (iterations 10..12) in the middle of a stream of in-grid pixels.
  // Pixels captured at iterations 5..12 are flushed or ignored, so their slots read as zero.
  task automatic test_reset_mid();
    stim_t s;
    exp_t ex;
    exp_t zero_ex;
    mix_en = 1'b0;
    set_banks(8'h0A, 8'h0A, 8'h0A, 8'h0A, 8'h0A, 8'h0A, 8'h0A, 8'h0A, 8'h0A);
    zero_ex.rgb = 24'h0; zero_ex.hs = 1'b0; zero_ex.vs = 1'b0; zero_ex.act = 1'b0;
    s = mk(40, 40, 1'b0, 1'b0, 1'b1, 3, 0);
    for (int i = 0; i < 29; i++) begin
      rst_in = (i >= 10 && i < 13);
      if (i < 24) begin
        s.h = 40 + 4 * i;
        drive(s);
        sb_pix.push_back((i >= 5 && i < 13) ? zero_ex : model(s));
      end else drive(mk(0, 0, 1'b0, 1'b0, 1'b0, 3, 0));
      tick();
      if (i >= 10 && i <= 13) begin
        checks++;
        if (read_en_out !== 1'b0 || addr_out !== '0)
          $display("FAIL rstmid_addr[%0d]: got ren=%b addr=%0d, want ren=0 addr=0",
                   i, read_en_out, addr_out[0]);
        else passes++;
      end
      if (i >= 5) begin
        ex = sb_pix.pop_front();
        checks++;
        if ({red_out, green_out, blue_out, hsync_out, vsync_out, active_out} !== {ex.rgb, ex.hs, ex.vs, ex.act})
          $display("FAIL rstmid_pix[%0d]: got %02h%02h%02h/%b%b%b, want %06h/%b%b%b", i,
                   red_out, green_out, blue_out, hsync_out, vsync_out, active_out, ex.rgb, ex.hs, ex.vs, ex.act);
        else passes++;
      end
    end
    rst_in = 1'b0;
    last_addr = (s.v / 4) * 205 + s.h / 4;
  endtask

  initial begin
    for (int b = 0; b < 9; b++) bank_val[b] = 8'h00;
    test_reset();
    test_density();
    test_boundary();
    test_velocity();
    test_busy_sync();
    test_back_to_back();
    test_reset_mid();
    test_density();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
